// File: rtl/riscv_mem_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mem_pkg
// Shared types and defaults for the memory-request arbitration path.
//   MEM_ARB_MAX_REQ         : largest number of requesters an arb_id_t can name
//   MEM_ARB_DEF_OUTSTANDING : default depth of the outstanding-ID FIFO
//   arb_id_t                : requester index carried through the ID FIFO
//   arb_state_e             : arbiter FSM states
// -----------------------------------------------------------------------------
package riscv_mem_pkg;

  localparam int MEM_ARB_MAX_REQ         = 8;
  localparam int MEM_ARB_DEF_OUTSTANDING = 4;

  typedef logic [2:0] arb_id_t;

  typedef enum logic {
    ARB,
    HOLD
  } arb_state_e;

endpackage

// File: rtl/arb_id_fifo.sv
// -----------------------------------------------------------------------------
// arb_id_fifo
// Synchronous FIFO of requester IDs, one entry per request still waiting for
// its downstream response.
//   i_clk    : clock
//   i_rst_n  : synchronous active-low reset, empties the FIFO
//   i_push   : write i_id (ignored when full)
//   i_id     : ID to store
//   i_pop    : drop the head entry (ignored when empty)
//   o_id     : head entry
//   o_full   : occupancy == DEPTH
//   o_empty  : occupancy == 0
//   o_count  : current occupancy
// -----------------------------------------------------------------------------
module arb_id_fifo
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = MEM_ARB_DEF_OUTSTANDING
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  arb_id_t                    i_id,
  input  logic                       i_pop,
  output arb_id_t                    o_id,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  arb_id_t         r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_id    = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_id;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
// Round-robin arbiter sharing one downstream memory request/response channel
// among NUM_REQ requesters. Requests pass through combinationally; the grant
// is locked while the downstream stalls. Granted IDs are queued in order so
// each downstream response is routed back to the requester that issued it.
//   clk_i / rst_ni        : clock, synchronous active-low reset
//   req_*                 : upstream request channel, packed per requester
//   rsp_*                 : upstream response channel (valid one-hot, data shared)
//   mem_req_* / mem_rsp_* : downstream request and response channels
//   outstanding_o         : number of requests awaiting a response
// -----------------------------------------------------------------------------
module mem_req_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = MEM_ARB_DEF_OUTSTANDING
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0]            req_addr_i,
  input  logic [NUM_REQ-1:0]                   req_write_i,
  input  logic [NUM_REQ*DATA_W-1:0]            req_wdata_i,
  output logic [NUM_REQ-1:0]                   rsp_valid_o,
  input  logic [NUM_REQ-1:0]                   rsp_ready_i,
  output logic [DATA_W-1:0]                    rsp_rdata_o,
  output logic                                 rsp_error_o,
  output logic                                 mem_req_valid_o,
  input  logic                                 mem_req_ready_i,
  output logic [ADDR_W-1:0]                    mem_req_addr_o,
  output logic                                 mem_req_write_o,
  output logic [DATA_W-1:0]                    mem_req_wdata_o,
  input  logic                                 mem_rsp_valid_i,
  output logic                                 mem_rsp_ready_o,
  input  logic [DATA_W-1:0]                    mem_rsp_rdata_i,
  input  logic                                 mem_rsp_error_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  arb_state_e           r_state;
  arb_id_t              r_rr_ptr;
  arb_id_t              r_grant;

  arb_id_t              w_winner;
  arb_id_t              w_sel;
  arb_id_t              w_head;
  logic [NUM_REQ-1:0]   w_sel_oh;
  logic [NUM_REQ-1:0]   w_head_oh;
  logic                 w_req_valid;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_rsp_active;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  function automatic arb_id_t rr_pick(input logic [NUM_REQ-1:0] valid,
                                      input arb_id_t ptr);
    arb_id_t pick;
    logic    found;
    int      idx;
    pick  = ptr;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && valid[idx]) begin
        pick  = arb_id_t'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic arb_id_t rr_next(input arb_id_t id);
    return (id == arb_id_t'(NUM_REQ - 1)) ? '0 : id + arb_id_t'(1);
  endfunction

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_push),
    .i_id    (w_sel),
    .i_pop   (w_pop),
    .o_id    (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (outstanding_o)
  );

  assign w_winner = rr_pick(req_valid_i, r_rr_ptr);
  assign w_sel    = (r_state == HOLD) ? r_grant : w_winner;

  // HOLD never needs a fullness check: it is entered only when not full and
  // nothing is pushed until it exits. Full blocks on the registered count, so
  // a same-cycle pop does not free a slot until the next cycle.
  assign w_req_valid = rst_ni && ((r_state == HOLD) || (!w_full && (|req_valid_i)));
  assign w_push      = w_req_valid && mem_req_ready_i;

  always_comb begin
    w_sel_oh  = '0;
    w_head_oh = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sel_oh[k]  = (w_sel == arb_id_t'(k));
      w_head_oh[k] = (w_head == arb_id_t'(k));
    end
  end

  // Downstream payload is muxed from the selected requester, zero when idle.
  always_comb begin
    mem_req_addr_o  = '0;
    mem_req_write_o = 1'b0;
    mem_req_wdata_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_req_valid && w_sel_oh[k]) begin
        mem_req_addr_o  = req_addr_i[k*ADDR_W +: ADDR_W];
        mem_req_write_o = req_write_i[k];
        mem_req_wdata_o = req_wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign mem_req_valid_o = w_req_valid;
  assign req_ready_o     = w_sel_oh & {NUM_REQ{w_push}};

  assign w_rsp_active    = rst_ni && !w_empty;
  assign rsp_valid_o     = w_head_oh & {NUM_REQ{w_rsp_active && mem_rsp_valid_i}};
  assign mem_rsp_ready_o = w_rsp_active && (|(w_head_oh & rsp_ready_i));
  assign rsp_rdata_o     = w_rsp_active ? mem_rsp_rdata_i : '0;
  assign rsp_error_o     = w_rsp_active && mem_rsp_error_i;
  assign w_pop           = mem_rsp_valid_i && mem_rsp_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= ARB;
      r_rr_ptr <= '0;
      r_grant  <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_req_valid) begin
            if (mem_req_ready_i) begin
              r_rr_ptr <= rr_next(w_winner);
            end else begin
              r_grant <= w_winner;
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (mem_req_ready_i) begin
            r_rr_ptr <= rr_next(r_grant);
            r_state  <= ARB;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  a_rsp_not_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rsp_valid_i |-> !w_empty);
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_push && w_full));
  a_req_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));
  a_rsp_valid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(rsp_valid_o));
  a_hold_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == HOLD) |-> (|(req_valid_i & w_sel_oh)));

endmodule

// File: tb/tb_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_req_arbiter
// Directed scenarios followed by randomized traffic, all compared each cycle
// against a queue-based reference model of the arbiter.
// -----------------------------------------------------------------------------
module tb_mem_req_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic                 clk;
  logic                 rstN;
  logic [NREQ-1:0]      reqValid;
  logic [NREQ-1:0]      reqWrite;
  logic [NREQ-1:0]      rspReady;
  logic [AW-1:0]        reqAddr [NREQ];
  logic [DW-1:0]        reqWdata [NREQ];
  logic [NREQ*AW-1:0]   reqAddrBus;
  logic [NREQ*DW-1:0]   reqWdataBus;
  logic                 memReqReady;
  logic                 memRspValid;
  logic                 memRspError;
  logic [DW-1:0]        memRspRdata;

  logic [NREQ-1:0]      reqReady;
  logic [NREQ-1:0]      rspValid;
  logic [DW-1:0]        rspRdata;
  logic                 rspError;
  logic                 memReqValid;
  logic [AW-1:0]        memReqAddr;
  logic                 memReqWrite;
  logic [DW-1:0]        memReqWdata;
  logic                 memRspReady;
  logic [2:0]           outstanding;

  int checks;
  int failures;

  // Reference model: in-order queue of granted IDs, a round-robin pointer and
  // a lock on the requester that was offered downstream but not yet accepted.
  int              q[$];
  int              rrPtr;
  bit              locked;
  int              lockedId;
  logic [NREQ-1:0] lastReqReady;

  mem_req_arbiter #(
    .NUM_REQ         (NREQ),
    .ADDR_W          (AW),
    .DATA_W          (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rstN),
    .req_valid_i     (reqValid),
    .req_ready_o     (reqReady),
    .req_addr_i      (reqAddrBus),
    .req_write_i     (reqWrite),
    .req_wdata_i     (reqWdataBus),
    .rsp_valid_o     (rspValid),
    .rsp_ready_i     (rspReady),
    .rsp_rdata_o     (rspRdata),
    .rsp_error_o     (rspError),
    .mem_req_valid_o (memReqValid),
    .mem_req_ready_i (memReqReady),
    .mem_req_addr_o  (memReqAddr),
    .mem_req_write_o (memReqWrite),
    .mem_req_wdata_o (memReqWdata),
    .mem_rsp_valid_i (memRspValid),
    .mem_rsp_ready_o (memRspReady),
    .mem_rsp_rdata_i (memRspRdata),
    .mem_rsp_error_i (memRspError),
    .outstanding_o   (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    reqAddrBus  = '0;
    reqWdataBus = '0;
    for (int k = 0; k < NREQ; k++) begin
      reqAddrBus[k*AW +: AW]  = reqAddr[k];
      reqWdataBus[k*DW +: DW] = reqWdata[k];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits until just after a rising edge, then drives a full input set so it
  // is stable across the next check point and commit edge.
  task automatic applyStimulus(input logic r, input logic [NREQ-1:0] v, input logic [NREQ-1:0] wr,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic mrdy,
                               input logic rv, input logic [DW-1:0] rdata, input logic rerr,
                               input logic [NREQ-1:0] rrdy);
    @(posedge clk);
    #1;
    rstN        = r;
    reqValid    = v;
    reqWrite    = wr;
    reqAddr[0]  = a0;
    reqAddr[1]  = a1;
    reqWdata[0] = a0 ^ 32'h5A5A_5A5A;
    reqWdata[1] = a1 ^ 32'hC3C3_0001;
    memReqReady = mrdy;
    memRspValid = rv;
    memRspRdata = rdata;
    memRspError = rerr;
    rspReady    = rrdy;
  endtask

  // Compares all outputs against the model mid-cycle, then advances the model
  // by the commit that the coming rising edge will perform.
  task automatic runCycle();
    bit              expMemValid;
    int              expId;
    logic [NREQ-1:0] expReqReady;
    logic [NREQ-1:0] expRspValid;
    logic            expMemRspReady;
    @(negedge clk);
    #1;
    if (!rstN) begin
      checkOutput("rst_memReqValid", 64'(memReqValid), 64'd0);
      checkOutput("rst_reqReady", 64'(reqReady), 64'd0);
      checkOutput("rst_rspValid", 64'(rspValid), 64'd0);
      checkOutput("rst_memRspReady", 64'(memRspReady), 64'd0);
      q.delete();
      rrPtr        = 0;
      locked       = 1'b0;
      lastReqReady = '0;
      return;
    end
    expMemValid = 1'b0;
    expId       = 0;
    if (locked) begin
      expMemValid = 1'b1;
      expId       = lockedId;
    end else if (q.size() < MAXO) begin
      for (int off = 0; off < NREQ; off++) begin
        if (!expMemValid && reqValid[(rrPtr + off) % NREQ]) begin
          expMemValid = 1'b1;
          expId       = (rrPtr + off) % NREQ;
        end
      end
    end
    expReqReady    = (expMemValid && memReqReady) ? NREQ'(1 << expId) : '0;
    expRspValid    = (q.size() > 0 && memRspValid) ? NREQ'(1 << q[0]) : '0;
    expMemRspReady = (q.size() > 0) ? rspReady[q[0]] : 1'b0;

    checkOutput("outstanding", 64'(outstanding), 64'(q.size()));
    checkOutput("memReqValid", 64'(memReqValid), 64'(expMemValid));
    checkOutput("reqReady", 64'(reqReady), 64'(expReqReady));
    if (expMemValid) begin
      checkOutput("memReqAddr", 64'(memReqAddr), 64'(reqAddr[expId]));
      checkOutput("memReqWrite", 64'(memReqWrite), 64'(reqWrite[expId]));
      checkOutput("memReqWdata", 64'(memReqWdata), 64'(reqWdata[expId]));
    end
    checkOutput("rspValid", 64'(rspValid), 64'(expRspValid));
    checkOutput("memRspReady", 64'(memRspReady), 64'(expMemRspReady));
    if (expRspValid != '0) begin
      checkOutput("rspRdata", 64'(rspRdata), 64'(memRspRdata));
      checkOutput("rspError", 64'(rspError), 64'(memRspError));
    end

    if (q.size() > 0 && memRspValid && rspReady[q[0]]) void'(q.pop_front());
    if (expMemValid && memReqReady) begin
      q.push_back(expId);
      rrPtr  = (expId + 1) % NREQ;
      locked = 1'b0;
    end else if (expMemValid) begin
      locked   = 1'b1;
      lockedId = expId;
    end
    lastReqReady = expReqReady;
  endtask

  task automatic doReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
      runCycle();
    end
  endtask

  initial begin
    logic [NREQ-1:0] expGrant;
    int              grants0;
    int              grants1;
    logic [NREQ-1:0] pv;
    logic [NREQ-1:0] pw;
    logic [AW-1:0]   pa [NREQ];
    logic            rv;

    checks   = 0;
    failures = 0;
    rrPtr    = 0;
    locked   = 1'b0;
    lockedId = 0;

    doReset();

    // Single requester: zero-latency request and response pass-through.
    applyStimulus(1'b1, 2'b01, 2'b00, 32'h1000, 32'h0, 1'b1, 1'b0, '0, 1'b0, 2'b11);
    runCycle();
    checkOutput("t1_addr", 64'(memReqAddr), 64'h1000);
    checkOutput("t1_ready", 64'(reqReady), 64'h1);
    applyStimulus(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'b11);
    runCycle();
    checkOutput("t1_outstanding", 64'(outstanding), 64'd1);
    checkOutput("t1_rspValid", 64'(rspValid), 64'h1);
    checkOutput("t1_rdata", 64'(rspRdata), 64'hDEAD_BEEF);
    applyStimulus(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 2'b11);
    runCycle();
    checkOutput("t1_drained", 64'(outstanding), 64'd0);

    // Round-robin fairness with both requesters always valid.
    doReset();
    grants0 = 0;
    grants1 = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'b11, 2'b00, 32'h2000, 32'h3000, 1'b1, 1'b0, '0, 1'b0, 2'b11);
      runCycle();
      expGrant = (i % 2 == 0) ? 2'b01 : 2'b10;
      checkOutput($sformatf("t2_grant%0d", i), 64'(reqReady), 64'(expGrant));
      if (reqReady[0]) grants0++;
      if (reqReady[1]) grants1++;
    end
    checkOutput("t2_count0", 64'(grants0), 64'd2);
    checkOutput("t2_count1", 64'(grants1), 64'd2);

    // Downstream backpressure locks the grant on req0.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'b11, 2'b00, 32'h4000, 32'h5000, 1'b0, 1'b0, '0, 1'b0, 2'b11);
      runCycle();
      checkOutput($sformatf("t3_holdAddr%0d", i), 64'(memReqAddr), 64'h4000);
      checkOutput($sformatf("t3_holdReady%0d", i), 64'(reqReady), 64'h0);
    end
    applyStimulus(1'b1, 2'b11, 2'b00, 32'h4000, 32'h5000, 1'b1, 1'b0, '0, 1'b0, 2'b11);
    runCycle();
    checkOutput("t3_release", 64'(reqReady), 64'h1);
    applyStimulus(1'b1, 2'b10, 2'b00, 32'h0, 32'h5000, 1'b1, 1'b0, '0, 1'b0, 2'b11);
    runCycle();
    checkOutput("t3_nextGrant", 64'(reqReady), 64'h2);
    checkOutput("t3_nextAddr", 64'(memReqAddr), 64'h5000);

    // Full FIFO blocks grants until the cycle after a pop.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'b01, 2'b00, 32'h6000, 32'h0, 1'b1, 1'b0, '0, 1'b0, 2'b11);
      runCycle();
    end
    applyStimulus(1'b1, 2'b01, 2'b00, 32'h6000, 32'h0, 1'b1, 1'b0, '0, 1'b0, 2'b11);
    runCycle();
    checkOutput("t4_fullBlocks", 64'(memReqValid), 64'd0);
    checkOutput("t4_fullCount", 64'(outstanding), 64'd4);
    applyStimulus(1'b1, 2'b01, 2'b00, 32'h6000, 32'h0, 1'b1, 1'b1, 32'h11, 1'b0, 2'b11);
    runCycle();
    checkOutput("t4_noGrantOnPop", 64'(memReqValid), 64'd0);
    checkOutput("t4_popReady", 64'(memRspReady), 64'd1);
    applyStimulus(1'b1, 2'b01, 2'b00, 32'h6000, 32'h0, 1'b1, 1'b0, '0, 1'b0, 2'b11);
    runCycle();
    checkOutput("t4_grantAfterPop", 64'(reqReady), 64'h1);

    // Response routing, response backpressure and error pass-through.
    doReset();
    applyStimulus(1'b1, 2'b10, 2'b10, 32'h0, 32'h7000, 1'b1, 1'b0, '0, 1'b0, 2'b11);
    runCycle();
    checkOutput("t5_writeGrant", 64'(reqReady), 64'h2);
    checkOutput("t5_writeFlag", 64'(memReqWrite), 64'd1);
    applyStimulus(1'b1, 2'b01, 2'b00, 32'h7100, 32'h0, 1'b1, 1'b0, '0, 1'b0, 2'b11);
    runCycle();
    checkOutput("t5_readGrant", 64'(reqReady), 64'h1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hAAAA, 1'b0, 2'b01);
      runCycle();
      checkOutput($sformatf("t5_route1_%0d", i), 64'(rspValid), 64'h2);
      checkOutput($sformatf("t5_bp%0d", i), 64'(memRspReady), 64'd0);
    end
    applyStimulus(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hAAAA, 1'b0, 2'b11);
    runCycle();
    checkOutput("t5_accept1", 64'(memRspReady), 64'd1);
    applyStimulus(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hBBBB, 1'b1, 2'b11);
    runCycle();
    checkOutput("t5_route0", 64'(rspValid), 64'h1);
    checkOutput("t5_error", 64'(rspError), 64'd1);

    // Reset with requests in flight discards them.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'b01, 2'b00, 32'h7800, 32'h0, 1'b1, 1'b0, '0, 1'b0, 2'b11);
      runCycle();
    end
    applyStimulus(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, '0, 1'b0, 2'b11);
    runCycle();
    applyStimulus(1'b1, 2'b10, 2'b00, 32'h0, 32'h8000, 1'b1, 1'b0, '0, 1'b0, 2'b11);
    runCycle();
    checkOutput("t6_outstanding", 64'(outstanding), 64'd0);
    checkOutput("t6_grant", 64'(reqReady), 64'h2);
    checkOutput("t6_addr", 64'(memReqAddr), 64'h8000);

    // Randomized traffic; requesters hold each request until accepted.
    doReset();
    pv = '0;
    pw = '0;
    pa[0] = '0;
    pa[1] = '0;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!pv[k] && ($urandom % 2 == 0)) begin
          pv[k] = 1'b1;
          pa[k] = $urandom;
          pw[k] = 1'($urandom % 2);
        end
      end
      rv = (q.size() > 0) && ($urandom % 2 == 0);
      applyStimulus(1'b1, pv, pw, pa[0], pa[1], 1'($urandom % 4 != 0), rv,
                    $urandom, 1'($urandom % 8 == 0), NREQ'($urandom));
      runCycle();
      pv = pv & ~lastReqReady;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
Round-robin arbiter that shares one downstream memory request/response channel among NUM_REQ upstream requesters (per-core L1 I-cache and D-cache ports, or the single-core I/D pair ahead of the memory wrapper). It grants one request per accepted beat and locks the grant until the downstream handshake completes. It records the granted requester ID in an in-order outstanding-ID FIFO and routes each downstream response back to the requester that issued it.

Parameters:
NUM_REQ, 2, number of upstream requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_OUTSTANDING, 4, depth of the outstanding-ID FIFO (power of 2, ≥2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester request accepted
req_addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester k occupies [k*ADDR_W +: ADDR_W]
req_write_i  in  NUM_REQ  1 = write
req_wdata_i  in  NUM_REQ*DATA_W  packed write data
rsp_valid_o  out  NUM_REQ  one-hot response valid
rsp_ready_i  in  NUM_REQ  per-requester response ready
rsp_rdata_o  out  DATA_W  response data, shared by all requesters
rsp_error_o  out  1  response error, shared by all requesters
mem_req_valid_o  out  1  downstream request valid
mem_req_ready_i  in  1  downstream request ready
mem_req_addr_o  out  ADDR_W  downstream address
mem_req_write_o  out  1  downstream write
mem_req_wdata_o  out  DATA_W  downstream write data
mem_rsp_valid_i  in  1  downstream response valid
mem_rsp_ready_o  out  1  downstream response ready
mem_rsp_rdata_i  in  DATA_W  downstream response data
mem_rsp_error_i  in  1  downstream response error
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current FIFO occupancy, for debug and PMU use

Behaviour:
- Clocking and reset: one clock domain (clk_i). Reset is synchronous, active-low (rst_ni).
- State reset values: rr_ptr=0, state=ARB, FIFO empty, outstanding_o=0.
- Output reset values: while in reset, all *_valid_o, req_ready_o and mem_rsp_ready_o are 0. Data outputs are don't-care but driven 0 when idle.
- FSM states: ARB, HOLD.
  - ARB: if FIFO is not full and any req_valid_i is set, grant the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    - Drive mem_req_* from the winner combinationally: zero-cycle request latency.
    - mem_req_ready_i=1 → req_ready_o[winner]=1, push winner ID into the FIFO, set rr_ptr=winner+1 (wrapping), stay in ARB.
    - mem_req_ready_i=0 → latch the winner into grant_q and go to HOLD.
  - HOLD: mem_req_* is driven from grant_q only; no re-arbitration.
    - On mem_req_ready_i=1: push, ready the granted requester, update rr_ptr, return to ARB.
    - Requesters must hold valid and payload stable until ready. Dropping valid in HOLD is a protocol violation; flag it with an assertion.
- FIFO full (count==MAX_OUTSTANDING): mem_req_valid_o=0 in ARB. No grant is issued even if a pop occurs in the same cycle; the grant is issued the following cycle.
- Response path:
  - FIFO empty → mem_rsp_ready_o=0.
  - Otherwise, head ID h: rsp_valid_o = one-hot(h) & {NUM_REQ{mem_rsp_valid_i}}, rsp_rdata_o=mem_rsp_rdata_i, rsp_error_o=mem_rsp_error_i, mem_rsp_ready_o=rsp_ready_i[h].
  - Pop on mem_rsp_valid_i && mem_rsp_ready_o. Combinational pass-through: zero-cycle response latency.
- Ordering: responses are assumed in-order downstream. Both reads and writes produce exactly one response.
- Simultaneous push and pop (not full): occupancy unchanged, both pointers advance. Pointers wrap modulo MAX_OUTSTANDING.
- Assertions:
  - mem_rsp_valid_i with FIFO empty is an error.
  - FIFO overflow is an error.
  - req_ready_o is one-hot0.
  - rsp_valid_o is one-hot0.
- Reset mid-operation: all outstanding IDs are discarded. The downstream is also reset by the same rst_ni, so no orphaned responses arrive.

Decomposition:
- Shared package riscv_mem_pkg: MEM_ARB_MAX_REQ=8, typedef arb_id_t = logic [2:0], default MAX_OUTSTANDING.
- Sub-module arb_id_fifo: synchronous FIFO of arb_id_t with push/pop/full/empty/count.
- The round-robin pick is a function inside mem_req_arbiter.

Test Plan:
1. Single requester: NUM_REQ=2, req0 read 0x1000, mem_req_ready_i=1 → mem_req_addr_o=0x1000 in the same cycle, outstanding_o=1. Response 0xDEADBEEF → rsp_valid_o=2'b01, rsp_rdata_o=0xDEADBEEF, outstanding_o=0.
2. Round-robin fairness: both requesters valid continuously, ready=1 → grant order 0,1,0,1 over 4 cycles; each requester receives exactly 2 grants.
3. Backpressure hold: req0 granted with mem_req_ready_i=0 for 3 cycles while req1 asserts valid → mem_req_addr_o stays at req0's address and req_ready_o=00 for 3 cycles. Ready then rises → req_ready_o=01; next grant goes to req1.
4. Full FIFO: MAX_OUTSTANDING=4, issue 4 requests with no responses → 5th request sees mem_req_valid_o=0. A response pops in cycle N → 5th request is granted in cycle N+1.
5. Response routing and backpressure: issue req1 write then req0 read. First response goes to req1 (rsp_valid_o=10); hold rsp_ready_i[1]=0 for 2 cycles → mem_rsp_ready_o=0 for those cycles. Second response goes to req0 with rsp_error_o=1 when mem_rsp_error_i=1.
6. Reset mid-flight: 3 outstanding, assert rst_ni=0 for 1 cycle → outstanding_o=0, rr_ptr=0, all valid/ready outputs 0. The next request from req1 is granted immediately.
